// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: ID->EXE forwarding select and load-use/no-forward stall with an in-flight destination tracker
// Define FWD_STATS_EN to build the saturating stall_cnt/fwd_cnt counters; otherwise both read 0.
module fwd_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH = 3,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     forward_en,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] ex_src_sel,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              fwd_cnt
);
  // The last stage needs no entry: its register write is visible to same-cycle ID reads.
  localparam int N = DEPTH - 1;
  logic [N-1:0] v, w, m;
  logic [REG_W-1:0] d [N];
  logic [NUM_SRC*SEL_W-1:0] next_sel;
  logic load_use, any_hit, h;
  always_comb begin
    next_sel = '0;
    load_use = 1'b0;
    any_hit = 1'b0;
    h = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = N - 1; k >= 0; k--) begin
        h = id_valid & id_src_used[i] & v[k] & w[k] & (id_src[i*REG_W +: REG_W] == d[k]);
        any_hit = any_hit | h;
        load_use = load_use | (h & (k == 0) & m[0]);
        if (h && forward_en) next_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    stall = ~flush & (forward_en ? load_use : any_hit);
  end
  wire bubble = flush | stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      w <= '0;
      m <= '0;
      for (int k = 0; k < N; k++) d[k] <= '0;
      ex_src_sel <= '0;
    end else if (!freeze) begin
      for (int k = N - 1; k > 0; k--) begin
        v[k] <= v[k-1];
        w[k] <= w[k-1];
        m[k] <= m[k-1];
        d[k] <= d[k-1];
      end
      v[0] <= bubble ? 1'b0 : id_valid;
      w[0] <= bubble ? 1'b0 : id_wb_en;
      m[0] <= bubble ? 1'b0 : id_mem_read;
      d[0] <= bubble ? '0 : id_dest;
      ex_src_sel <= bubble ? '0 : next_sel;
    end
  end
`ifdef FWD_STATS_EN
  logic [31:0] sc, fc, nz;
  logic [32:0] fsum;
  always_comb begin
    nz = '0;
    for (int i = 0; i < NUM_SRC; i++) nz = nz + 32'(next_sel[i*SEL_W +: SEL_W] != '0);
    fsum = {1'b0, fc} + {1'b0, nz};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
      fc <= '0;
    end else if (!freeze) begin
      if (stall && sc != '1) sc <= sc + 32'd1;
      if (!bubble) fc <= fsum[32] ? '1 : fsum[31:0];
    end
  end
  assign stall_cnt = sc;
  assign fwd_cnt = fc;
`else
  assign stall_cnt = '0;
  assign fwd_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenario tasks for fwd_hazard_ctrl with hand-computed expectations
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, forward_en = 1'b1, freeze = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [7:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [3:0] id_dest = '0;
  logic id_wb_en = 1'b0, id_mem_read = 1'b0, stall;
  logic [3:0] ex_src_sel;
  logic [31:0] stall_cnt, fwd_cnt;
  int passed = 0, total = 0;
`ifdef FWD_STATS_EN
  localparam logic [31:0] ONE = 32'd1;
`else
  localparam logic [31:0] ONE = 32'd0;
`endif

  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .stall(stall), .ex_src_sel(ex_src_sel),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                       input logic [3:0] dest, input logic wb, input logic mr);
    id_valid = v; id_src = {s1, s0}; id_src_used = used; id_dest = dest; id_wb_en = wb; id_mem_read = mr;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
    total++; if (ex_src_sel !== 4'h0) $display("FAIL reset_sel got %h want 0", ex_src_sel); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passed++;
    total++; if (fwd_cnt !== 32'd0) $display("FAIL reset_fwd_cnt got %0d want 0", fwd_cnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_exe();
    drive(1'b1, 4'd2, 4'd3, 2'b11, 4'd1, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL exe_add_stall got %b want 0", stall); else passed++;
    tick();
    drive(1'b1, 4'd1, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL exe_sub_stall got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h1) $display("FAIL exe_sel got %h want 1", ex_src_sel); else passed++;
    idle(3);
  endtask

  task automatic test_fwd_mem_wb();
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0);
    tick();
    idle(1);
    drive(1'b1, 4'd1, 4'd7, 2'b11, 4'd5, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mem_stall got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h2) $display("FAIL mem_sel got %h want 2", ex_src_sel); else passed++;
    idle(3);
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0);
    tick();
    idle(2);
    drive(1'b1, 4'd1, 4'd1, 2'b11, 4'd5, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL wb_stall got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h0) $display("FAIL wb_sel got %h want 0", ex_src_sel); else passed++;
    idle(3);
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    s0 = stall_cnt; f0 = fwd_cnt;
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd9, 4'd2, 2'b11, 4'd8, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h0) $display("FAIL lu_bubble_sel got %h want 0", ex_src_sel); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL lu_release got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h8) $display("FAIL lu_sel got %h want 8", ex_src_sel); else passed++;
    total++; if (stall_cnt - s0 !== ONE) $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt - s0, ONE); else passed++;
    total++; if (fwd_cnt - f0 !== ONE) $display("FAIL lu_fwd_cnt got %0d want %0d", fwd_cnt - f0, ONE); else passed++;
    idle(3);
  endtask

  task automatic test_stall_only();
    forward_en = 1'b0;
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd3, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL so_stall1 got %b want 1", stall); else passed++;
    tick();
    total++; if (stall !== 1'b1) $display("FAIL so_stall2 got %b want 1", stall); else passed++;
    tick();
    total++; if (stall !== 1'b0) $display("FAIL so_stall3 got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h0) $display("FAIL so_sel got %h want 0", ex_src_sel); else passed++;
    forward_en = 1'b1;
    idle(3);
  endtask

  task automatic test_flush_freeze();
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else passed++;
    tick();
    flush = 1'b0;
    total++; if (ex_src_sel !== 4'h0) $display("FAIL flush_sel got %h want 0", ex_src_sel); else passed++;
    drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_bubble got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h2) $display("FAIL post_flush_sel got %h want 2", ex_src_sel); else passed++;
    drive(1'b1, 4'd6, 4'd0, 2'b01, 4'd7, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (ex_src_sel !== 4'h2) $display("FAIL freeze_sel%0d got %h want 2", c, ex_src_sel); else passed++;
    end
    freeze = 1'b0;
    tick();
    total++; if (ex_src_sel !== 4'h1) $display("FAIL unfreeze_sel got %h want 1", ex_src_sel); else passed++;
    idle(3);
  endtask

  task automatic test_src_unused();
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd1, 4'd1, 2'b00, 4'd5, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL unused_stall got %b want 0", stall); else passed++;
    tick();
    total++; if (ex_src_sel !== 4'h0) $display("FAIL unused_sel got %h want 0", ex_src_sel); else passed++;
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd4, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1);
    tick();
    total++; if (ex_src_sel !== 4'h1) $display("FAIL mid_pre_sel got %h want 1", ex_src_sel); else passed++;
    drive(1'b1, 4'd0, 4'd2, 2'b10, 4'd9, 1'b1, 1'b0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL mid_pre_stall got %b want 1", stall); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mid_rst_stall got %b want 0", stall); else passed++;
    total++; if (ex_src_sel !== 4'h0) $display("FAIL mid_rst_sel got %h want 0", ex_src_sel); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL mid_rst_stall_cnt got %0d want 0", stall_cnt); else passed++;
    total++; if (fwd_cnt !== 32'd0) $display("FAIL mid_rst_fwd_cnt got %0d want 0", fwd_cnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_fwd_exe();
    test_fwd_mem_wb();
    test_load_use();
    test_stall_only();
    test_flush_freeze();
    test_src_unused();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
